// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
// Included by the top level and by the round-robin grant logic.
package mem_arb_pkg;

  localparam int NUM_REQ    = 2;
  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RD,
    RESP
  } arb_state_e;

  function automatic logic [NUM_REQ-1:0] grant_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mem_rr_arbiter.sv
// Combinational round-robin pick between two requesters.
// When both are valid, the requester not served last time wins.
module mem_rr_arbiter
  import mem_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_valid_i,
  input  logic               last_grant_i,
  output logic               grant_idx_o,
  output logic               grant_any_o
);

  always_comb begin
    grant_any_o = |req_valid_i;
    grant_idx_o = 1'b0;
    unique case (req_valid_i)
      2'b01:   grant_idx_o = 1'b0;
      2'b10:   grant_idx_o = 1'b1;
      2'b11:   grant_idx_o = ~last_grant_i;
      default: grant_idx_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Round-robin sequencer placing one read or write at a time onto a single-port memory,
// returning read data to the requester that issued it after RD_LAT cycles.
module mem_req_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_LAT = 1
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  input  logic [NUM_REQ-1:0]     req_we_i,
  input  logic [2*ADDR_W-1:0]    req_addr_i,
  input  logic [2*DATA_W-1:0]    req_wdata_i,
  output logic [NUM_REQ-1:0]     rsp_valid_o,
  output logic [DATA_W-1:0]      rsp_rdata_o,
  output logic [ADDR_W-1:0]      address_o,
  output logic                   wr_en_o,
  output logic                   rd_en_o,
  output logic [DATA_W-1:0]      wdata_o,
  input  logic [DATA_W-1:0]      rdata_i
);

  localparam int CNT_W = $clog2(RD_LAT + 1);

  arb_state_e          state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic                we_q, we_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_REQ-1:0]  req_ready_q, req_ready_d;
  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [ADDR_W-1:0]   address_q, address_d;
  logic                wr_en_q, wr_en_d;
  logic                rd_en_q, rd_en_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;

  logic                grant_idx;
  logic                grant_any;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  mem_rr_arbiter u_rr (
    .req_valid_i  (req_valid_i),
    .last_grant_i (last_grant_q),
    .grant_idx_o  (grant_idx),
    .grant_any_o  (grant_any)
  );

  assign sel_we    = grant_idx ? req_we_i[1] : req_we_i[0];
  assign sel_addr  = grant_idx ? req_addr_i[2*ADDR_W-1:ADDR_W] : req_addr_i[ADDR_W-1:0];
  assign sel_wdata = grant_idx ? req_wdata_i[2*DATA_W-1:DATA_W] : req_wdata_i[DATA_W-1:0];

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      we_q         <= 1'b0;
      cnt_q        <= '0;
      req_ready_q  <= '0;
      rsp_valid_q  <= '0;
      rsp_rdata_q  <= '0;
      address_q    <= '0;
      wr_en_q      <= 1'b0;
      rd_en_q      <= 1'b0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= req_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      address_q    <= address_d;
      wr_en_q      <= wr_en_d;
      rd_en_q      <= rd_en_d;
      wdata_q      <= wdata_d;
    end
  end

  // Outputs are registered, so the ISSUE-cycle pin values are loaded on the IDLE->ISSUE edge.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    cnt_d        = cnt_q;
    req_ready_d  = '0;
    rsp_valid_d  = '0;
    rsp_rdata_d  = rsp_rdata_q;
    address_d    = address_q;
    wr_en_d      = 1'b0;
    rd_en_d      = 1'b0;
    wdata_d      = wdata_q;

    unique case (state_q)
      IDLE: begin
        if (grant_any) begin
          last_grant_d = grant_idx;
          we_d         = sel_we;
          address_d    = sel_addr;
          if (sel_we) begin
            wdata_d = sel_wdata;
          end
          req_ready_d  = grant_onehot(grant_idx);
          wr_en_d      = sel_we;
          rd_en_d      = ~sel_we;
          state_d      = ISSUE;
        end
      end

      ISSUE: begin
        if (we_q) begin
          state_d = IDLE;
        end else begin
          cnt_d   = CNT_W'(RD_LAT);
          state_d = WAIT_RD;
        end
      end

      WAIT_RD: begin
        if (cnt_q == CNT_W'(1)) begin
          rsp_rdata_d = rdata_i;
          rsp_valid_d = grant_onehot(last_grant_q);
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign address_o   = address_q;
  assign wr_en_o     = wr_en_q;
  assign rd_en_o     = rd_en_q;
  assign wdata_o     = wdata_q;

endmodule
